// File: rtl/sweep_pkg.sv
// Shared types and default sizes for the sweep sequencer slice.
package sweep_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int NSW_W_DEF = 4;

  // Sequencer states: idle, counting towards hi, counting back towards lo.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

endpackage

// File: rtl/updown_core.sv
// Loadable up/down counter datapath driven by the sweep sequencer FSM.
// Load has priority over counting; no wrap protection is needed because
// the controller never steps outside the latched bounds.
module updown_core #(
  parameter int WIDTH = sweep_pkg::WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_enable,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count register: async clear, then load, then step in the requested direction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable) begin
      if (i_up) r_count <= r_count + WIDTH'(1);
      else      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/sweep_sequencer.sv
// Ping-pong sweep controller: runs the count lo->hi->lo for a programmed
// number of periods (0 = forever), with pause, abort, busy and done.
// Handshake: i_start is a request level sampled only while idle; it is
// accepted on the first edge where the FSM is idle, i_abort is low and the
// bounds are legal (lo < hi). There is no ready: o_busy high means any
// further request is ignored, and o_cfg_err pulses when a request is refused.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NSW_W = NSW_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [NSW_W-1:0] i_sweeps,
  output logic [WIDTH-1:0] o_count,
  output logic             o_dir,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_cfg_err,
  output state_t           o_state
);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_lo, r_hi;
  logic [NSW_W-1:0] r_sweeps, r_sweep_cnt;
  logic             r_dir, r_busy, r_done, r_cfg_err;

  logic [WIDTH-1:0] w_lo_nxt, w_hi_nxt;
  logic [NSW_W-1:0] w_sweeps_nxt, w_sweep_cnt_nxt, w_sweep_cnt_inc;
  logic             w_dir_nxt, w_busy_nxt, w_done_nxt, w_cfg_err_nxt;
  logic             w_load, w_enable, w_up;
  logic [WIDTH-1:0] w_load_value;
  logic [WIDTH-1:0] w_count;

  assign w_sweep_cnt_inc = r_sweep_cnt + NSW_W'(1);

  updown_core #(.WIDTH(WIDTH)) u_core (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .i_enable     (w_enable),
    .i_up         (w_up),
    .o_count      (w_count)
  );

  // Next-state and datapath control; abort beats pause, pause freezes everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_lo_nxt        = r_lo;
    w_hi_nxt        = r_hi;
    w_sweeps_nxt    = r_sweeps;
    w_sweep_cnt_nxt = r_sweep_cnt;
    w_dir_nxt       = r_dir;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_cfg_err_nxt   = 1'b0;
    w_load          = 1'b0;
    w_load_value    = r_lo;
    w_enable        = 1'b0;
    w_up            = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          if (i_lo >= i_hi) begin
            w_cfg_err_nxt = 1'b1;
          end else begin
            w_lo_nxt        = i_lo;
            w_hi_nxt        = i_hi;
            w_sweeps_nxt    = i_sweeps;
            w_sweep_cnt_nxt = '0;
            w_load          = 1'b1;
            w_load_value    = i_lo;
            w_dir_nxt       = 1'b1;
            w_busy_nxt      = 1'b1;
            w_state_nxt     = S_UP;
          end
        end
      end

      S_UP, S_DOWN: begin
        if (i_abort) begin
          w_load       = 1'b1;
          w_load_value = r_lo;
          w_dir_nxt    = 1'b1;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = S_IDLE;
        end else if (!i_pause) begin
          w_enable = 1'b1;
          if (r_state == S_UP) begin
            w_up = 1'b1;
            // Turn around on the edge that makes the count reach hi.
            if (w_count + WIDTH'(1) == r_hi) begin
              w_dir_nxt   = 1'b0;
              w_state_nxt = S_DOWN;
            end
          end else begin
            w_up = 1'b0;
            // Returning to lo closes one full period.
            if (w_count - WIDTH'(1) == r_lo) begin
              w_sweep_cnt_nxt = w_sweep_cnt_inc;
              if (r_sweeps != '0 && w_sweep_cnt_inc == r_sweeps) begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
              end else begin
                w_dir_nxt   = 1'b1;
                w_state_nxt = S_UP;
              end
            end
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_dir_nxt   = 1'b1;
      end
    endcase
  end

  // Control registers: state, latched configuration, status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_sweeps    <= '0;
      r_sweep_cnt <= '0;
      r_dir       <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lo        <= w_lo_nxt;
      r_hi        <= w_hi_nxt;
      r_sweeps    <= w_sweeps_nxt;
      r_sweep_cnt <= w_sweep_cnt_nxt;
      r_dir       <= w_dir_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_cfg_err   <= w_cfg_err_nxt;
    end
  end

  assign o_count   = w_count;
  assign o_dir     = r_dir;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_cfg_err = r_cfg_err;
  assign o_state   = r_state;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer: one task per scenario, inline checks.
module tb_sweep_sequencer;
  import sweep_pkg::*;

  logic       clock, reset;
  logic       i_start, i_pause, i_abort;
  logic [3:0] i_lo, i_hi, i_sweeps;
  logic [3:0] o_count;
  logic       o_dir, o_busy, o_done, o_cfg_err;
  state_t     o_state;

  int total = 0;
  int bad   = 0;

  sweep_sequencer #(.WIDTH(4), .NSW_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_start   (i_start),
    .i_pause   (i_pause),
    .i_abort   (i_abort),
    .i_lo      (i_lo),
    .i_hi      (i_hi),
    .i_sweeps  (i_sweeps),
    .o_count   (o_count),
    .o_dir     (o_dir),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_cfg_err (o_cfg_err),
    .o_state   (o_state)
  );

  // Clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected ping-pong position n active edges after the start edge.
  function automatic logic [3:0] ping(int lo, int hi, int n);
    int d, pos;
    d   = hi - lo;
    pos = n % (2 * d);
    if (pos <= d) return 4'(lo + pos);
    return 4'(hi - (pos - d));
  endfunction

  task automatic issue_start(logic [3:0] lo, logic [3:0] hi, logic [3:0] sw);
    i_lo = lo; i_hi = hi; i_sweeps = sw; i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 0; i_pause = 0; i_abort = 0;
    i_lo = 0; i_hi = 0; i_sweeps = 0;
    #12;
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    total++; if (o_dir !== 1'b1) begin bad++; $display("FAIL reset_dir got=%b exp=1", o_dir); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", o_done); end
    total++; if (o_cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b exp=0", o_cfg_err); end
    total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", o_state, S_IDLE); end
    @(negedge clock);
    reset = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    issue_start(4'd0, 4'd15, 4'd1);
    for (int n = 1; n <= 7; n++) step();
    total++; if (o_count !== 4'd7) begin bad++; $display("FAIL areset_pre_count got=%0d exp=7", o_count); end
    #2 reset = 1'b1;
    #1;
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL areset_count got=%0d exp=0", o_count); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b exp=0", o_busy); end
    total++; if (o_dir !== 1'b1) begin bad++; $display("FAIL areset_dir got=%b exp=1", o_dir); end
    @(negedge clock);
    reset = 1'b0;
    step();
    total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL areset_state got=%0d exp=%0d", o_state, S_IDLE); end
  endtask

  task automatic test_full_sweep();
    issue_start(4'd0, 4'd15, 4'd1);
    total++; if (o_count !== 4'd0 || o_busy !== 1'b1 || o_dir !== 1'b1) begin
      bad++; $display("FAIL full_start got count=%0d busy=%b dir=%b exp 0/1/1", o_count, o_busy, o_dir); end
    for (int n = 1; n <= 15; n++) begin
      step();
      total++; if (o_count !== 4'(n)) begin bad++; $display("FAIL full_up n=%0d got=%0d exp=%0d", n, o_count, n); end
    end
    total++; if (o_dir !== 1'b0) begin bad++; $display("FAIL full_dir_at_hi got=%b exp=0", o_dir); end
    for (int n = 1; n <= 15; n++) begin
      step();
      total++; if (o_count !== 4'(15 - n)) begin bad++; $display("FAIL full_down n=%0d got=%0d exp=%0d", n, o_count, 15 - n); end
      total++; if (o_done !== (n == 15) || o_busy !== (n != 15)) begin
        bad++; $display("FAIL full_flags n=%0d got done=%b busy=%b", n, o_done, o_busy); end
    end
    step();
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL full_done_clear got=%b exp=0", o_done); end
  endtask

  task automatic test_cfg_err();
    issue_start(4'd5, 4'd5, 4'd1);
    total++; if (o_cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_pulse got=%b exp=1", o_cfg_err); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL cfg_err_busy got=%b exp=0", o_busy); end
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL cfg_err_count got=%0d exp=0", o_count); end
    step();
    total++; if (o_cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_clear got=%b exp=0", o_cfg_err); end
    total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL cfg_err_state got=%0d exp=%0d", o_state, S_IDLE); end
  endtask

  task automatic test_pause();
    issue_start(4'd2, 4'd6, 4'd2);
    step(); step();
    total++; if (o_count !== 4'd4) begin bad++; $display("FAIL pause_pre got=%0d exp=4", o_count); end
    i_pause = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      total++; if (o_count !== 4'd4 || o_busy !== 1'b1 || o_dir !== 1'b1) begin
        bad++; $display("FAIL pause_hold got count=%0d busy=%b dir=%b exp 4/1/1", o_count, o_busy, o_dir); end
    end
    i_pause = 1'b0;
    for (int t = 6; t <= 19; t++) begin
      step();
      total++; if (o_count !== ping(2, 6, t - 3)) begin
        bad++; $display("FAIL pause_count t=%0d got=%0d exp=%0d", t, o_count, ping(2, 6, t - 3)); end
      total++; if (o_done !== (t == 19) || o_busy !== (t != 19)) begin
        bad++; $display("FAIL pause_flags t=%0d got done=%b busy=%b", t, o_done, o_busy); end
    end
  endtask

  task automatic test_abort();
    issue_start(4'd0, 4'd9, 4'd0);
    for (int n = 1; n <= 28; n++) begin
      step();
      total++; if (o_count !== ping(0, 9, n) || o_done !== 1'b0) begin
        bad++; $display("FAIL abort_run n=%0d got count=%0d done=%b exp=%0d/0", n, o_count, o_done, ping(0, 9, n)); end
    end
    total++; if (o_dir !== 1'b0) begin bad++; $display("FAIL abort_pre_dir got=%b exp=0", o_dir); end
    i_abort = 1'b1; i_start = 1'b1; i_lo = 4'd3; i_hi = 4'd7; i_sweeps = 4'd1;
    step();
    i_abort = 1'b0; i_start = 1'b0;
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL abort_count got=%0d exp=0", o_count); end
    total++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_dir !== 1'b1) begin
      bad++; $display("FAIL abort_flags got busy=%b done=%b dir=%b exp 0/0/1", o_busy, o_done, o_dir); end
    total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL abort_state got=%0d exp=%0d", o_state, S_IDLE); end
    step();
    total++; if (o_count !== 4'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++; $display("FAIL abort_after got count=%0d busy=%b done=%b", o_count, o_busy, o_done); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [0:6];
    exp_seq = '{4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd4, 4'd3};
    issue_start(4'd3, 4'd4, 4'd3);
    total++; if (o_count !== exp_seq[0]) begin bad++; $display("FAIL b2b n=0 got=%0d exp=%0d", o_count, exp_seq[0]); end
    for (int n = 1; n <= 6; n++) begin
      if (n == 1) begin
        i_start = 1'b1; i_lo = 4'd0; i_hi = 4'd9; i_sweeps = 4'd1;
      end else begin
        i_start = 1'b0;
      end
      step();
      total++; if (o_count !== exp_seq[n]) begin bad++; $display("FAIL b2b n=%0d got=%0d exp=%0d", n, o_count, exp_seq[n]); end
      total++; if (o_done !== (n == 6) || o_busy !== (n != 6)) begin
        bad++; $display("FAIL b2b_flags n=%0d got done=%b busy=%b", n, o_done, o_busy); end
    end
    issue_start(4'd1, 4'd3, 4'd1);
    total++; if (o_count !== 4'd1 || o_busy !== 1'b1 || o_done !== 1'b0) begin
      bad++; $display("FAIL restart got count=%0d busy=%b done=%b exp 1/1/0", o_count, o_busy, o_done); end
    for (int n = 1; n <= 4; n++) step();
    total++; if (o_count !== 4'd1 || o_done !== 1'b1 || o_busy !== 1'b0) begin
      bad++; $display("FAIL restart_done got count=%0d done=%b busy=%b exp 1/1/0", o_count, o_done, o_busy); end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_full_sweep();
    test_cfg_err();
    test_pause();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sweep_sequencer.md
# sweep_sequencer

Controller that sequences an up/down (ping-pong) counter datapath between programmable bounds for a programmed number of sweeps. It accepts a start request, drives the counter through lo→hi→lo periods, supports pause and abort, and reports busy/done. It sits between the control logic that issues sweep requests and the consumers of the count value.

## Interface
- WIDTH, 4, count and bound width
- NSW_W, 4, width of sweep-count field
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  sweep request, sampled only in IDLE
- pause  in  1  level; freezes sequencing while high
- abort  in  1  synchronous cancel; highest priority after reset
- lo  in  WIDTH  lower bound, latched on accepted start
- hi  in  WIDTH  upper bound, latched on accepted start
- sweeps  in  NSW_W  number of full lo→hi→lo periods; 0 = run until abort
- count  out  WIDTH  counter value
- dir  out  1  1 = counting up, 0 = counting down
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at normal completion
- cfg_err  out  1  one-cycle pulse on rejected start

## Operation
- Reset (asynchronous, any state): count=0, dir=1, busy=0, done=0, cfg_err=0, state IDLE, sweep counter 0, latched bounds 0.
- States: IDLE, UP, DOWN.
- IDLE: count holds. start=1 and abort=0: if lo>=hi (unsigned) → cfg_err=1 for one cycle, remain IDLE; else latch lo/hi/sweeps, count<=lo, dir<=1, busy<=1, sweep counter<=0, → UP.
- UP (pause=0): count<=count+1; on the edge count becomes hi, dir<=0 → DOWN.
- DOWN (pause=0): count<=count-1; on the edge count becomes lo, the period completes: increment sweep counter; if sweeps≠0 and counter+1==sweeps → IDLE, busy<=0, done<=1; else dir<=1 → UP.
- pause=1 in UP/DOWN: count, dir, state, and sweep counter frozen; busy stays 1. pause is ignored in IDLE.
- abort=1 in UP/DOWN: → IDLE, busy<=0, count<=latched lo, dir<=1, no done pulse. abort overrides pause and start.
- start while busy: ignored; inputs lo/hi/sweeps are not re-latched.
- Arithmetic: unsigned WIDTH-bit; count never leaves [lo,hi], so no wrap occurs. hi==lo+1 alternates lo,hi each cycle.
- sweeps=0: sweep counter wraps freely (NSW_W bits) and never terminates.
- done and cfg_err are registered and clear on the next edge.

## Timing
- Start sampled at edge k → count=lo, busy=1 after k.
- count=hi after edge k+(hi−lo); count=lo after edge k+2(hi−lo) per period.
- N sweeps: the final return to lo, busy=0, and done=1 all appear after edge k+2N(hi−lo). done is low after the next edge.
- Each paused cycle delays all subsequent events by exactly one cycle.
- Earliest restart: start at the edge after done is visible.
- Reset mid-sweep takes effect immediately, independent of clock.

## Structure
- Package sweep_pkg: state enum typedef (S_IDLE, S_UP, S_DOWN) and default WIDTH/NSW_W constants.
- Sub-module updown_core: count register with load, load_value, enable, and up inputs, and asynchronous reset to 0. The FSM in sweep_sequencer drives it.

## Test plan
- Reset mid-UP at count=7 → count=0, busy=0, dir=1 immediately, before the next clock edge.
- lo=0, hi=15, sweeps=1, start at edge k → count 0..15 by k+15, dir=0 at count 15, count=0 with done=1 and busy=0 at k+30.
- lo=5, hi=5, start → cfg_err pulses one cycle, busy stays 0, count unchanged.
- lo=2, hi=6, sweeps=2, pause held 3 cycles at count=4 while going up → count holds 4, done is delayed to k+16+3=k+19.
- lo=0, hi=9, sweeps=0, abort at count=8 while going down, with start also high → IDLE, count=0, no done, start ignored.
- lo=3, hi=4, sweeps=3 → count alternates 3,4,3,4,3,4,3 with done at k+6; a start issued while busy has no effect.
